// File: rtl/vec_issue_queue.sv
// Vector issue queue: FWFT FIFO of {instruction, operands} between scalar and vector pipes.
// Optional same-cycle empty-queue bypass when VEC_IQ_BYPASS_EN is defined.
module vec_issue_queue #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int NUM_OPS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inst_valid,
  output logic                      inst_ready,
  input  logic [XLEN-1:0]           instruction,
  input  logic [NUM_OPS*XLEN-1:0]   rs_data,
  input  logic                      flush,
  output logic                      iq_valid,
  input  logic                      iq_ready,
  output logic [XLEN-1:0]           iq_instruction,
  output logic [NUM_OPS*XLEN-1:0]   iq_rs_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                      full,
  output logic                      empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = NUM_OPS*XLEN;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [OW-1:0]   ops;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic          byp_present, byp_take;
  entry_t        head;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign inst_ready = !full && !flush;

`ifdef VEC_IQ_BYPASS_EN
  // Empty queue shows the incoming word directly; it is only stored if not taken now.
  assign byp_present = empty && inst_valid && !flush;
  assign byp_take    = byp_present && iq_ready;
`else
  assign byp_present = 1'b0;
  assign byp_take    = 1'b0;
`endif

  assign head           = mem_q[rd_ptr_q];
  assign iq_valid       = !empty || byp_present;
  assign iq_instruction = byp_present ? instruction : head.inst;
  assign iq_rs_data     = byp_present ? rs_data     : head.ops;

  assign push = inst_valid && inst_ready && !byp_take;
  assign pop  = !empty && iq_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; validity is tracked solely by pointers and count.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= '{inst: instruction, ops: rs_data};
  end

endmodule
